// File: rtl/rotate_sequencer_if.sv
// Bundle of the requester, result and status signals of rotate_sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface rotate_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_dir;
  logic [AMT_W-1:0] req0_amt;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_dir;
  logic [AMT_W-1:0] req1_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_dir, req0_amt,
    input  req1_valid, req1_data, req1_dir, req1_amt,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, busy
  );

  modport master (
    output req0_valid, req0_data, req0_dir, req0_amt,
    output req1_valid, req1_data, req1_dir, req1_amt,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/rotate_sequencer.sv
// Round-robin front end sharing one rotate engine between two requesters.
// ROTATE_FAST_EN: rotate in the accept cycle with a barrel shifter instead of bit-serial steps.
module rotate_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic               clk,
  input logic               rst,
  rotate_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             last_grant_q;
  logic             out_valid_q;
  logic             busy_q;
`ifndef ROTATE_FAST_EN
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
`endif

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] sel_data;
  logic             sel_dir;
  logic [AMT_W-1:0] sel_amt;
  logic [AMT_W-1:0] amt_d;

  // Doubling the word turns a rotate into a plain shift followed by a slice.
  function automatic logic [WIDTH-1:0] rot_by(input logic [WIDTH-1:0] d,
                                              input logic right,
                                              input logic [AMT_W-1:0] k);
    logic [2*WIDTH-1:0] dd;
    if (right) begin
      dd = {d, d} >> k;
      rot_by = dd[WIDTH-1:0];
    end else begin
      dd = {d, d} << k;
      rot_by = dd[2*WIDTH-1:WIDTH];
    end
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_valid & ~grant_id;
  assign bus.req1_ready = grant_valid & grant_id;

  assign sel_data = grant_id ? bus.req1_data : bus.req0_data;
  assign sel_dir  = grant_id ? bus.req1_dir  : bus.req0_dir;
  assign sel_amt  = grant_id ? bus.req1_amt  : bus.req0_amt;
  assign amt_d    = AMT_W'(32'(sel_amt) % WIDTH);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifndef ROTATE_FAST_EN
      cnt_q        <= '0;
      dir_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            busy_q       <= 1'b1;
`ifdef ROTATE_FAST_EN
            data_q       <= rot_by(sel_data, sel_dir, amt_d);
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
`else
            data_q       <= sel_data;
            dir_q        <= sel_dir;
            cnt_q        <= amt_d;
            if (amt_d == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ROTATE;
            end
`endif
          end
        end
`ifndef ROTATE_FAST_EN
        ROTATE: begin
          data_q <= rot_by(data_q, dir_q, AMT_W'(1));
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
